// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian push-button synchroniser, debouncer and latched crossing request
// Feeds traffic_light: request held until ack, then a lockout window blocks new presses.
module ped_request #(
  parameter int CLK_FREQ       = 25000000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LOCKOUT_S      = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  input  logic       ack_i,
  output logic       req_o,
  output logic       wait_led_o,
  output logic       lockout_o,
  output logic [7:0] press_count_o
);

  localparam longint DB_RAW    = (longint'(CLK_FREQ) * longint'(DEBOUNCE_MS)) / 1000;
  localparam longint LO_RAW    = longint'(CLK_FREQ) * longint'(LOCKOUT_S);
  localparam int     DB_CYCLES = (DB_RAW < 1) ? 1 : int'(DB_RAW);
  localparam int     LO_CYCLES = (LO_RAW < 1) ? 1 : int'(LO_RAW);
  localparam int     DB_W      = ($clog2(DB_CYCLES + 1) < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam int     LO_W      = ($clog2(LO_CYCLES) < 1) ? 1 : $clog2(LO_CYCLES);
  localparam logic   RELEASED  = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              sync1, sync2;
  logic              db_state, db_prev;
  logic [DB_W-1:0]   db_cnt;
  logic [LO_W-1:0]   lo_cnt;
  logic [7:0]        press_count;
  logic              press_evt;
  logic              count_en;
  logic              lo_load;

  // Everything on the button side resets to the released level so reset can never look like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= RELEASED;
      sync2    <= RELEASED;
      db_state <= RELEASED;
      db_prev  <= RELEASED;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_i;
      sync2   <= sync1;
      db_prev <= db_state;
      if (sync2 == db_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
        db_state <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press_evt = (db_state != RELEASED) && (db_prev == RELEASED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_en = 1'b0;
    lo_load  = 1'b0;
    case (state)
      IDLE: begin
        if (press_evt) begin
          state_n  = PENDING;
          count_en = 1'b1;
        end
      end
      PENDING: begin
        if (ack_i) begin
          state_n = LOCKOUT;
          lo_load = 1'b1;
        end
      end
      LOCKOUT: begin
        if (lo_cnt == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_cnt      <= '0;
      press_count <= '0;
    end else begin
      if (lo_load) begin
        lo_cnt <= LO_W'(LO_CYCLES - 1);
      end else if ((state == LOCKOUT) && (lo_cnt != '0)) begin
        lo_cnt <= lo_cnt - 1'b1;
      end
      if (count_en && (press_count != 8'hff)) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  assign req_o         = (state == PENDING);
  assign wait_led_o    = req_o;
  assign lockout_o     = (state == LOCKOUT);
  assign press_count_o = press_count;

endmodule

// File: tb/tb_ped_request.sv
// tb/tb_ped_request.sv - self-checking bench for ped_request
// Scoreboard holds the expected count and arrival cycle of each request rise.
module tb_ped_request;

  logic       clk = 1'b0;
  logic       rst, btn, ack;
  logic       req, wait_led, lockout;
  logic [7:0] count;
  logic       btn_s, ack_s;
  logic       req_s, wait_s, lockout_s;
  logic [7:0] count_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int cnt;
    int due;
  } sb_t;
  sb_t  sb[$];
  sb_t  e;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ped_request #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(5), .LOCKOUT_S(2), .BTN_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .ack_i(ack),
    .req_o(req), .wait_led_o(wait_led), .lockout_o(lockout), .press_count_o(count)
  );

  // Tiny clock, active-high button: debounce of 1 cycle, lockout of 4.
  ped_request #(
    .CLK_FREQ(4), .DEBOUNCE_MS(5), .LOCKOUT_S(1), .BTN_ACTIVE_LOW(1'b0)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .btn_i(btn_s), .ack_i(ack_s),
    .req_o(req_s), .wait_led_o(wait_s), .lockout_o(lockout_s), .press_count_o(count_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_req(input int cnt, input int due);
    sb_t t;
    t.cnt = cnt;
    t.due = due;
    sb.push_back(t);
  endtask

  always @(negedge clk) begin
    if (req && !req_prev) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_req", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_cnt", int'(count), e.cnt);
        check("sb_latency", cyc, e.due);
      end
    end
    req_prev = req;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int elapsed, k, lo_hi, req_hi, to, exp;
    rst = 1'b1; btn = 1'b1; ack = 1'b0; btn_s = 1'b0; ack_s = 1'b0;
    tick(2);
    check("rst_req", req, 0);
    check("rst_wait", wait_led, 0);
    check("rst_lockout", lockout, 0);
    check("rst_count", count, 0);
    check("rst_sat_req", req_s, 0);
    check("rst_sat_count", count_s, 0);
    rst = 1'b0;
    tick(2);

    // clean press: request exactly 8 edges later
    expect_req(1, cyc + 8);
    btn = 1'b0;
    tick(7);
    check("t1_early", req, 0);
    tick(1);
    check("t1_req", req, 1);
    check("t1_wait", wait_led, 1);
    check("t1_count", count, 1);
    btn = 1'b1; rst = 1'b1;
    tick(2);
    check("t1_rst_count", count, 0);
    rst = 1'b0;
    tick(2);

    // bounce rejection
    elapsed = 0;
    while (elapsed < 40) begin
      k = int'($urandom_range(1, 4));
      btn = 1'b0; tick(k);
      btn = 1'b1; tick(3);
      elapsed += k + 3;
    end
    tick(10);
    check("t2_bounce_req", req, 0);
    check("t2_bounce_count", count, 0);
    expect_req(1, cyc + 8);
    btn = 1'b0;
    tick(10);
    check("t2_stable_req", req, 1);
    check("t2_stable_count", count, 1);

    // ack and lockout, with a press inside the window
    ack = 1'b1; tick(1); ack = 1'b0;
    check("t3_ack_req", req, 0);
    check("t3_ack_lockout", lockout, 1);
    lo_hi = 0;
    for (int i = 0; i < 2005; i++) begin
      if (lockout) lo_hi++;
      if (i == 10)  btn = 1'b1;
      if (i == 100) btn = 1'b0;
      if (i == 130) btn = 1'b1;
      tick(1);
    end
    check("t3_lockout_len", lo_hi, 2000);
    check("t3_lockout_end", lockout, 0);
    check("t3_count_kept", count, 1);
    check("t3_no_req", req, 0);
    expect_req(2, cyc + 8);
    btn = 1'b0;
    tick(9);
    check("t3_new_req", req, 1);
    check("t3_new_count", count, 2);

    // button held across end of lockout
    ack = 1'b1; tick(1); ack = 1'b0;
    lo_hi = 0; req_hi = 0;
    for (int i = 0; i < 2030; i++) begin
      if (lockout) lo_hi++;
      if (req) req_hi++;
      tick(1);
    end
    check("t4_lockout_len", lo_hi, 2000);
    check("t4_held_no_req", req_hi, 0);
    check("t4_idle", lockout, 0);
    ack = 1'b1; tick(1); ack = 1'b0;
    tick(2);
    check("t4_ack_idle_lockout", lockout, 0);
    check("t4_ack_idle_req", req, 0);

    // press and ack together in IDLE: press wins
    btn = 1'b1; tick(10);
    expect_req(3, cyc + 8);
    btn = 1'b0; tick(7);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("t4_sim_idle_req", req, 1);
    check("t4_sim_idle_lockout", lockout, 0);
    check("t4_sim_idle_count", count, 3);

    // press and ack together in PENDING: lockout, press not counted
    btn = 1'b1; tick(10);
    btn = 1'b0; tick(7);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("t4_sim_pend_req", req, 0);
    check("t4_sim_pend_lockout", lockout, 1);
    check("t4_sim_pend_count", count, 3);

    // asynchronous reset in LOCKOUT, button held
    #2 rst = 1'b1;
    #1;
    check("t5_lo_rst_lockout", lockout, 0);
    check("t5_lo_rst_count", count, 0);
    check("t5_lo_rst_req", req, 0);
    tick(1); rst = 1'b0;
    req_hi = 0;
    for (int i = 0; i < 4; i++) begin if (req) req_hi++; tick(1); end
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin if (req) req_hi++; tick(1); end
    check("t5_lo_no_spurious", req_hi, 0);
    check("t5_lo_count", count, 0);

    // asynchronous reset in PENDING
    expect_req(1, cyc + 8);
    btn = 1'b0;
    tick(9);
    check("t5_pend_req", req, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_pend_rst_req", req, 0);
    check("t5_pend_rst_wait", wait_led, 0);
    check("t5_pend_rst_count", count, 0);
    tick(1); rst = 1'b0;
    req_hi = 0;
    for (int i = 0; i < 4; i++) begin if (req) req_hi++; tick(1); end
    btn = 1'b1;
    for (int i = 0; i < 20; i++) begin if (req) req_hi++; tick(1); end
    check("t5_pend_no_spurious", req_hi, 0);

    // counter saturation on the small instance
    for (int i = 0; i < 260; i++) begin
      btn_s = 1'b1;
      to = 0;
      while (!req_s && to < 20) begin tick(1); to++; end
      check("t6_req", req_s, 1);
      exp = (i + 1 > 255) ? 255 : i + 1;
      check("t6_count", count_s, exp);
      ack_s = 1'b1; tick(1); ack_s = 1'b0;
      btn_s = 1'b0;
      to = 0;
      while (lockout_s && to < 20) begin tick(1); to++; end
      tick(4);
    end
    check("t6_saturated", count_s, 255);
    check("t6_wait_off", wait_s, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
